// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for two serial-bus masters with slave-ID
// capture and a transfer watchdog.
module bus_arbiter #(
  parameter int SLAVE_LEN   = 2,
  parameter int TIMEOUT_LEN = 12,
  parameter int TIMEOUT     = 4095
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              approval_request,
  input  logic [1:0]              trans_done,
  input  logic [1:0]              tx_slave_select,
  output logic [1:0]              approval_grant,
  output logic                    arbitor_busy,
  output logic                    bus_busy,
  output logic                    master_sel,
  output logic [2**SLAVE_LEN-1:0] slave_sel,
  output logic                    slave_sel_valid,
  output logic                    timeout
);
  localparam int NS = 2**SLAVE_LEN;
  localparam int CW = $clog2(SLAVE_LEN + 1);
  localparam logic [1:0] IDLE = 2'd0, SSEL = 2'd1, XFER = 2'd2;
  logic [1:0]             state;
  logic                   last_master;
  logic [CW-1:0]          bit_cnt;
  logic [SLAVE_LEN-1:0]   id_shift, id_next;
  logic [TIMEOUT_LEN-1:0] wd_cnt;
  logic                   winner, req_m, done_m, wd_hit;
  always_comb begin
    winner  = approval_request[1] & (~approval_request[0] | ~last_master);
    req_m   = approval_request[master_sel];
    done_m  = trans_done[master_sel];
    wd_hit  = wd_cnt == TIMEOUT_LEN'(TIMEOUT - 1);
    id_next = SLAVE_LEN'({id_shift, tx_slave_select[master_sel]});
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      approval_grant  <= '0;
      arbitor_busy    <= 1'b0;
      bus_busy        <= 1'b0;
      master_sel      <= 1'b0;
      slave_sel       <= '0;
      slave_sel_valid <= 1'b0;
      timeout         <= 1'b0;
      last_master     <= 1'b1;
      bit_cnt         <= '0;
      id_shift        <= '0;
      wd_cnt          <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: if (|approval_request) begin
          state          <= SSEL;
          approval_grant <= winner ? 2'b10 : 2'b01;
          master_sel     <= winner;
          last_master    <= winner;
          arbitor_busy   <= 1'b1;
          bus_busy       <= 1'b1;
          bit_cnt        <= '0;
        end
        SSEL: if (!req_m) begin
          state          <= IDLE;
          approval_grant <= '0;
          arbitor_busy   <= 1'b0;
          bus_busy       <= 1'b0;
        end else begin
          id_shift <= id_next;
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(SLAVE_LEN - 1)) begin
            state           <= XFER;
            slave_sel       <= NS'(1) << id_next;
            slave_sel_valid <= 1'b1;
            arbitor_busy    <= 1'b0;
            wd_cnt          <= '0;
          end
        end
        XFER: begin
          wd_cnt <= wd_cnt + 1'b1;
          // done beats both abort and expiry; only a pure expiry pulses timeout
          if (done_m | !req_m | wd_hit) begin
            state           <= IDLE;
            approval_grant  <= '0;
            bus_busy        <= 1'b0;
            slave_sel       <= '0;
            slave_sel_valid <= 1'b0;
            timeout         <= !done_m & req_m;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Central arbiter for the serial system bus, shared by two master ports. Accepts approval requests, grants the bus round-robin, and shifts in the granted master's serial slave-select ID. It drives the bus mux selects, then holds the bus until that master signals transaction done, drops its request, or a watchdog timeout fires. It produces the `approval_grant`, `arbitor_busy` and `bus_busy` inputs consumed by each master port.

## Interface
Parameters:
- `SLAVE_LEN`, default 2: width of the serial slave ID; decoded to 2**SLAVE_LEN one-hot selects.
- `TIMEOUT_LEN`, default 12: width of the transfer watchdog counter.
- `TIMEOUT`, default 4095: maximum XFER cycles before forced release; range 1..2**TIMEOUT_LEN-1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `approval_request` in 2: bit i is the request from master i; level, held until done.
- `trans_done` in 2: bit i is master i transaction complete; sampled only for the granted master.
- `tx_slave_select` in 2: bit i is the serial slave-ID line from master i, MSB first.
- `approval_grant` out 2: one-hot grant, registered.
- `arbitor_busy` out 1: high while the arbiter is granting or receiving the slave ID.
- `bus_busy` out 1: high from grant until release.
- `master_sel` out 1: index of the current or last granted master; drives the bus mux.
- `slave_sel` out 2**SLAVE_LEN: one-hot decoded slave; drives the slave-side mux.
- `slave_sel_valid` out 1: high in XFER only.
- `timeout` out 1: one-cycle pulse on watchdog release.

## Operation
- Internal state: `last_master` (reset 1), `bit_cnt`, `id_shift[SLAVE_LEN-1:0]`, `wd_cnt[TIMEOUT_LEN-1:0]`.
- Reset (`reset`=0 at an edge) forces the following, from any state including mid-transfer:
  - state=IDLE;
  - `approval_grant`=00, `arbitor_busy`=0, `bus_busy`=0, `master_sel`=0, `slave_sel`=0, `slave_sel_valid`=0, `timeout`=0;
  - `last_master`=1, all counters 0.
- IDLE:
  - All grants 0, both busy flags 0.
  - If any request: winner = the only requester, or if both request, `!last_master`.
  - Set `approval_grant[winner]`=1, `master_sel`=winner, `arbitor_busy`=1, `bus_busy`=1, `last_master`=winner, `bit_cnt`=0, then go to SSEL.
- SSEL:
  - Each cycle, shift `tx_slave_select[master_sel]` into `id_shift` LSB-in (first bit received ends up as MSB) and increment `bit_cnt`.
  - When SLAVE_LEN bits have been taken, go to XFER with `slave_sel` = one-hot(id), `slave_sel_valid`=1, `arbitor_busy`=0, `wd_cnt`=0.
  - If the granted master drops `approval_request` during SSEL: abort to IDLE and clear all outputs. No timeout pulse.
- XFER: `wd_cnt` increments each cycle. Release to IDLE on the first of these conditions:
  - `trans_done[master_sel]`=1: normal release.
  - `approval_request[master_sel]`=0: abort.
  - `wd_cnt`==TIMEOUT-1 with no done: `timeout`=1 for the single cycle after release.
- On release, all of the following are cleared together in the same edge: grant, `bus_busy`, `slave_sel`, `slave_sel_valid`. `master_sel` holds its value.
- The non-granted master's `trans_done` and `tx_slave_select` are ignored.

## Timing
- Request seen at edge E0 → grant visible after E0 (1-cycle latency from a registered IDLE sample).
- Slave-ID bit k is sampled at edge E(k+1), for k=0..SLAVE_LEN-1. The master drives bit 0 in the first cycle it sees its grant.
- `slave_sel_valid` rises after edge E(SLAVE_LEN).
- A done sampled at edge D drops the grant after D. IDLE always lasts at least one cycle, giving a bus turnaround; the earliest re-grant is after D+1.
- A request arriving while busy is held and serviced on return to IDLE. With both masters continuously requesting, grants strictly alternate, so neither master can starve.
- `trans_done` and watchdog expiry in the same cycle: done wins, no `timeout` pulse.
- Done and request-drop in the same cycle: treated as a normal release.
- Requests from both masters in the same IDLE cycle: resolved by `last_master` as above. The first grant after reset goes to master 0.

## Test plan
- Reset behaviour: hold `reset`=0 for 2 cycles with requests=11 → all outputs 0. Release reset with requests=11 → `approval_grant`=01 one cycle later, `arbitor_busy`=1.
- Single transfer: master 1 requests and sends ID bits 1,0 (SLAVE_LEN=2) → `slave_sel`=0100 and `slave_sel_valid`=1 two cycles after grant. Pulse `trans_done[1]` → grant=00 next cycle, `bus_busy`=0.
- Fairness: both masters requesting continuously for 4 transfers → grant sequence 01,10,01,10, with exactly one IDLE cycle between consecutive grants.
- Watchdog: TIMEOUT=8, no done → release after exactly 8 XFER cycles, `timeout` high for 1 cycle. Repeat with done on the 8th cycle → no `timeout` pulse.
- Abort in SSEL: master 0 drops its request after the first ID bit → return to IDLE next cycle, `slave_sel_valid` never asserts, and a pending master 1 request is granted one cycle later.
- Reset mid-XFER: assert `reset`=0 while in XFER → all outputs 0 the next cycle. After reset release, the first grant goes to master 0.
